// File: rtl/bcd_conv_arb.sv
// ============================================================================
// Module : bcd_conv_arb
// Shared shift-add-3 binary-to-BCD converter, two-requester round-robin arbiter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module bcd_conv_arb #(
    parameter int BIN_W   = 20,
    parameter int DIGITS  = 6,
    parameter int MAX_VAL = 999_999
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  req_a,
    input  logic [BIN_W-1:0]      bin_a,
    input  logic                  req_b,
    input  logic [BIN_W-1:0]      bin_b,
    output logic                  gnt_a,
    output logic                  gnt_b,
    output logic                  busy,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  bcd_id,
    output logic                  bcd_ovf,
    output logic                  bcd_valid
);

    localparam int          CNT_W     = $clog2(BIN_W + 1);
    localparam int          BCD_W     = 4 * DIGITS;
    localparam logic [31:0] c_max_val = 32'(MAX_VAL);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [BIN_W-1:0]   r_bin;
    logic [BCD_W-1:0]   r_dig;
    logic               r_ovf;
    logic               r_owner;
    logic               r_last_b;

    logic [BCD_W-1:0]       w_corr;
    logic [BCD_W+BIN_W-1:0] w_shift;
    logic                   w_pick_b;
    logic [BIN_W-1:0]       w_sel_bin;
    logic                   w_sel_ovf;

    // Correct every digit before the shift so a doubled digit >= 10 carries cleanly.
    always_comb begin
        w_corr = r_dig;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_dig[4*i +: 4] > 4'd4)
                w_corr[4*i +: 4] = r_dig[4*i +: 4] + 4'd3;
        end
    end

    assign w_shift   = {w_corr, r_bin} << 1;
    assign w_pick_b  = req_b & (~req_a | ~r_last_b);
    assign w_sel_bin = w_pick_b ? bin_b : bin_a;
    assign w_sel_ovf = (32'(w_sel_bin) > c_max_val);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bin     <= '0;
            r_dig     <= '0;
            r_ovf     <= 1'b0;
            r_owner   <= 1'b0;
            r_last_b  <= 1'b1;
            gnt_a     <= 1'b0;
            gnt_b     <= 1'b0;
            busy      <= 1'b0;
            bcd_out   <= '0;
            bcd_id    <= 1'b0;
            bcd_ovf   <= 1'b0;
            bcd_valid <= 1'b0;
        end else begin
            gnt_a     <= 1'b0;
            gnt_b     <= 1'b0;
            bcd_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_a || req_b) begin
                        r_bin    <= w_sel_bin;
                        r_dig    <= '0;
                        r_ovf    <= w_sel_ovf;
                        r_owner  <= w_pick_b;
                        r_last_b <= w_pick_b;
                        gnt_a    <= ~w_pick_b;
                        gnt_b    <= w_pick_b;
                        busy     <= 1'b1;
                        r_cnt    <= '0;
                        r_state  <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_dig <= w_shift[BCD_W+BIN_W-1:BIN_W];
                    r_bin <= w_shift[BIN_W-1:0];
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(BIN_W - 1)) begin
                        bcd_out   <= r_ovf ? {DIGITS{4'h9}} : w_shift[BCD_W+BIN_W-1:BIN_W];
                        bcd_id    <= r_owner;
                        bcd_ovf   <= r_ovf;
                        bcd_valid <= 1'b1;
                        busy      <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bcd_conv_arb.sv
// ============================================================================
// Module : tb_bcd_conv_arb
// Directed vector table plus hand sequences for bcd_conv_arb.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_bcd_conv_arb;

    logic        clk;
    logic        rst_n;
    logic        req_a, req_b;
    logic [19:0] bin_a, bin_b;
    logic        gnt_a, gnt_b, busy, bcd_id, bcd_ovf, bcd_valid;
    logic [23:0] bcd_out;

    int n_tests = 0;
    int n_fail  = 0;

    bcd_conv_arb #(.BIN_W(20), .DIGITS(6), .MAX_VAL(999_999)) dut (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .req_a     (req_a),
        .bin_a     (bin_a),
        .req_b     (req_b),
        .bin_b     (bin_b),
        .gnt_a     (gnt_a),
        .gnt_b     (gnt_b),
        .busy      (busy),
        .bcd_out   (bcd_out),
        .bcd_id    (bcd_id),
        .bcd_ovf   (bcd_ovf),
        .bcd_valid (bcd_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ra;
        logic [19:0] ba;
        logic        rb;
        logic [19:0] bb;
        logic        exp_id;
        logic [23:0] exp_bcd;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference decimal conversion, saturating above 999_999.
    function automatic logic [23:0] ref_bcd(input int unsigned v);
        logic [23:0] r;
        int unsigned x;
        r = '0;
        if (v > 999_999) return 24'h999999;
        x = v;
        for (int i = 0; i < 6; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic run_conv(input logic ra, input logic [19:0] ba, input logic rb,
                            input logic [19:0] bb, input logic exp_id,
                            input logic [23:0] exp_bcd, input logic exp_ovf,
                            input string nm);
        int n;
        int busy_bad;
        @(negedge clk);
        req_a = ra; bin_a = ba; req_b = rb; bin_b = bb;
        n = 0;
        while (!(gnt_a || gnt_b) && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({nm, " gnt"}, {30'd0, gnt_b, gnt_a}, exp_id ? 32'd2 : 32'd1);
        req_a = 1'b0; req_b = 1'b0;
        n = 0; busy_bad = 0;
        while (!bcd_valid && n < 40) begin
            if (!busy) busy_bad++;
            @(negedge clk);
            n++;
        end
        chk({nm, " latency"}, n, 20);
        chk({nm, " busy"}, busy_bad, 0);
        chk({nm, " bcd"}, {8'd0, bcd_out}, {8'd0, exp_bcd});
        chk({nm, " id/ovf/busy"}, {29'd0, bcd_id, bcd_ovf, busy}, {29'd0, exp_id, exp_ovf, 1'b0});
    endtask

    initial begin
        int n, gb, ng, nv, errs;
        logic [3:0] order;
        int tv[4];

        vecs[0] = '{1'b1, 20'd123456, 1'b0, 20'd0,      1'b0, 24'h123456, 1'b0};
        vecs[1] = '{1'b1, 20'd111,    1'b1, 20'd654321, 1'b1, 24'h654321, 1'b0};
        vecs[2] = '{1'b1, 20'd42,     1'b1, 20'd7,      1'b0, 24'h000042, 1'b0};
        vecs[3] = '{1'b0, 20'd0,      1'b1, 20'd0,      1'b1, 24'h000000, 1'b0};
        vecs[4] = '{1'b0, 20'd0,      1'b1, 20'hFFFFF,  1'b1, 24'h999999, 1'b1};
        vecs[5] = '{1'b1, 20'd999999, 1'b0, 20'd0,      1'b0, 24'h999999, 1'b0};
        vecs[6] = '{1'b1, 20'd1000000,1'b0, 20'd0,      1'b0, 24'h999999, 1'b1};
        vecs[7] = '{1'b1, 20'd1,      1'b0, 20'd0,      1'b0, 24'h000001, 1'b0};
        vecs[8] = '{1'b0, 20'd0,      1'b1, 20'd10,     1'b1, 24'h000010, 1'b0};
        vecs[9] = '{1'b1, 20'd500000, 1'b1, 20'd9,      1'b0, 24'h500000, 1'b0};

        rst_n = 1'b0; req_a = 1'b0; req_b = 1'b0; bin_a = '0; bin_b = '0;
        repeat (3) @(negedge clk);
        chk("reset outputs", {5'd0, gnt_a, gnt_b, busy, bcd_out, bcd_id, bcd_ovf, bcd_valid}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++)
            run_conv(vecs[i].ra, vecs[i].ba, vecs[i].rb, vecs[i].bb,
                     vecs[i].exp_id, vecs[i].exp_bcd, vecs[i].exp_ovf, $sformatf("vec%0d", i));

        // Request from B while A is converting must wait for the next IDLE sample.
        @(negedge clk);
        req_a = 1'b1; bin_a = 20'd987654;
        n = 0;
        while (!gnt_a && n < 40) begin @(negedge clk); n++; end
        chk("busy-ign gnt_a", {31'd0, gnt_a}, 32'd1);
        req_a = 1'b0;
        repeat (4) @(negedge clk);
        req_b = 1'b1; bin_b = 20'd246;
        n = 0; gb = 0;
        while (!bcd_valid && n < 40) begin
            if (gnt_b) gb++;
            @(negedge clk);
            n++;
        end
        chk("busy-ign no gnt_b", gb, 0);
        chk("busy-ign A result", {7'd0, bcd_id, bcd_out}, {8'd0, 24'h987654});
        @(negedge clk);
        chk("busy-ign gnt_b next", {30'd0, gnt_b, bcd_valid}, 32'd2);
        chk("busy-ign A held", {8'd0, bcd_out}, {8'd0, 24'h987654});
        req_b = 1'b0;
        n = 0;
        while (!bcd_valid && n < 40) begin @(negedge clk); n++; end
        chk("busy-ign B result", {7'd0, bcd_id, bcd_out}, {8'd1, 24'h000246});

        // Reset in the middle of an A conversion; pointer would otherwise favour B.
        @(negedge clk);
        req_a = 1'b1; bin_a = 20'd55555;
        n = 0;
        while (!gnt_a && n < 40) begin @(negedge clk); n++; end
        req_a = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid reset outputs", {5'd0, gnt_a, gnt_b, busy, bcd_out, bcd_id, bcd_ovf, bcd_valid}, 32'd0);
        repeat (3) @(negedge clk);
        chk("mid reset no valid", {31'd0, bcd_valid | busy}, 32'd0);
        rst_n = 1'b1;
        req_a = 1'b1; bin_a = 20'd1;
        req_b = 1'b1; bin_b = 20'd999999;

        // Both requests held: grants alternate and results arrive 21 cycles apart.
        ng = 0; nv = 0; errs = 0; order = '0; n = 0;
        while (nv < 4 && n < 150) begin
            @(negedge clk);
            n++;
            if (gnt_a && gnt_b) errs++;
            if (bcd_valid && (gnt_a || gnt_b)) errs++;
            if ((gnt_a || gnt_b) && ng < 4) begin
                order[ng] = gnt_b;
                ng++;
            end
            if (bcd_valid) begin
                tv[nv] = n;
                if (bcd_out !== (bcd_id ? 24'h999999 : 24'h000001) || bcd_ovf) errs++;
                nv++;
            end
        end
        req_a = 1'b0; req_b = 1'b0;
        chk("fair grant count", ng, 4);
        chk("fair order", {28'd0, order}, 32'b1010);
        chk("fair valid count", nv, 4);
        chk("fair spacing 1", tv[1] - tv[0], 21);
        chk("fair spacing 3", tv[3] - tv[2], 21);
        chk("fair protocol/results", errs, 0);
        repeat (25) @(negedge clk);

        for (int v = 0; v <= 999_999; v += 4999)
            run_conv(1'b1, 20'(v), 1'b0, 20'd0, 1'b0, ref_bcd(v), 1'b0, $sformatf("sweep %0d", v));
        run_conv(1'b1, 20'd999_998, 1'b0, 20'd0, 1'b0, ref_bcd(999_998), 1'b0, "sweep 999998");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
